instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction memory with a program-load write port and a
// four-state fetch FSM. It hands registered instruction words to the decoder
// using a valid/ready handshake, pulses pc_inc after each accepted word, and
// enters HALTED when the accepted word carries the halt opcode.
module instr_fetch_unit #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 6,
  parameter logic [5:0]  HALT_OPC = 6'h3F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] instruction,
  output logic              ir_valid,
  output logic              fetch_busy,
  output logic              pc_inc,
  output logic              halt
);

  localparam int MemDepth = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetchAddr_q, fetchAddr_d;
  logic [DATA_W-1:0] instrWord_q, instrWord_d;
  logic              irValid_q, irValid_d;
  logic              pcInc_q, pcInc_d;

  logic [DATA_W-1:0] mem_q [0:MemDepth-1];

  logic memWrite;
  logic fetchStart;
  logic handshake;
  logic isHaltWord;

  // Decode the events that drive both the FSM and the datapath.
  always_comb begin
    memWrite   = load_en && ((state_q == IDLE) || (state_q == HALTED));
    fetchStart = (state_q == IDLE) && fetch_req && !load_en;
    handshake  = (state_q == HOLD) && ir_ready;
    isHaltWord = (instrWord_q[DATA_W-1 -: 6] == HALT_OPC);
  end

  // Program-load write port; memory is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (rst_n && memWrite) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a load in IDLE takes priority over a fetch request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetchStart) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (ir_ready) begin
          state_d = isHaltWord ? HALTED : IDLE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: address latch, registered read, valid flag, pc_inc.
  always_comb begin
    fetchAddr_d = fetchAddr_q;
    instrWord_d = instrWord_q;
    irValid_d   = irValid_q;
    pcInc_d     = 1'b0;
    if (fetchStart) begin
      fetchAddr_d = pc_addr;
    end
    if (state_q == READ) begin
      instrWord_d = mem_q[fetchAddr_q];
      irValid_d   = 1'b1;
    end
    if (handshake) begin
      irValid_d = 1'b0;
      pcInc_d   = !isHaltWord;
    end
  end

  // Datapath registers; the read port output lives in instrWord_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetchAddr_q <= '0;
      instrWord_q <= '0;
      irValid_q   <= 1'b0;
      pcInc_q     <= 1'b0;
    end else begin
      fetchAddr_q <= fetchAddr_d;
      instrWord_q <= instrWord_d;
      irValid_q   <= irValid_d;
      pcInc_q     <= pcInc_d;
    end
  end

  // State-decoded outputs.
  always_comb begin
    fetch_busy = (state_q != IDLE);
    halt       = (state_q == HALTED);
  end

  assign instruction = instrWord_q;
  assign ir_valid    = irValid_q;
  assign pc_inc      = pcInc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: load, fetch latency, stall,
// ignored loads, load/fetch collision, reset mid-HOLD, halt handling.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        fetch_req;
  logic [5:0]  pc_addr;
  logic        ir_ready;
  logic [31:0] instruction;
  logic        ir_valid;
  logic        fetch_busy;
  logic        pc_inc;
  logic        halt;

  int checks;
  int failures;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .fetch_req  (fetch_req),
    .pc_addr    (pc_addr),
    .ir_ready   (ir_ready),
    .instruction(instruction),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .pc_inc     (pc_inc),
    .halt       (halt)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then step past the next rising edge.
  task automatic applyStimulus(input logic ld, input logic [5:0] la,
                               input logic [31:0] ldat, input logic fr,
                               input logic [5:0] pa, input logic rdy);
    load_en   = ld;
    load_addr = la;
    load_data = ldat;
    fetch_req = fr;
    pc_addr   = pa;
    ir_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_instr"}, instruction, 32'h0);
    checkOutput({tag, "_valid"}, {31'd0, ir_valid}, 32'd0);
    checkOutput({tag, "_busy"},  {31'd0, fetch_busy}, 32'd0);
    checkOutput({tag, "_pcinc"}, {31'd0, pc_inc}, 32'd0);
    checkOutput({tag, "_halt"},  {31'd0, halt}, 32'd0);
  endtask

  task automatic loadWord(input logic [5:0] a, input logic [31:0] d);
    applyStimulus(1'b1, a, d, 1'b0, 6'd0, 1'b0);
  endtask

  // Request at edge N, then step edges N+1 and N+2 and check the word.
  task automatic fetchWord(input string tag, input logic [5:0] a,
                           input logic [31:0] expWord);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b1, a, 1'b0);
    checkOutput({tag, "_busyN"}, {31'd0, fetch_busy}, 32'd1);
    idleCycle();
    checkOutput({tag, "_busyN1"}, {31'd0, fetch_busy}, 32'd1);
    idleCycle();
    checkOutput({tag, "_validN2"}, {31'd0, ir_valid}, 32'd1);
    checkOutput({tag, "_instrN2"}, instruction, expWord);
  endtask

  // Accept the held word and check the single pc_inc pulse.
  task automatic acceptWord(input string tag);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b1);
    checkOutput({tag, "_validClr"}, {31'd0, ir_valid}, 32'd0);
    checkOutput({tag, "_pcinc1"}, {31'd0, pc_inc}, 32'd1);
    checkOutput({tag, "_idle"}, {31'd0, fetch_busy}, 32'd0);
    idleCycle();
    checkOutput({tag, "_pcinc0"}, {31'd0, pc_inc}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    fetch_req = 1'b0;
    pc_addr   = '0;
    ir_ready  = 1'b0;

    // Reset state.
    idleCycle();
    idleCycle();
    checkAllZero("reset");
    rst_n = 1'b1;

    // Program load stays in IDLE.
    loadWord(6'd5, 32'hA5A5A5A5);
    checkOutput("load_busy", {31'd0, fetch_busy}, 32'd0);
    loadWord(6'd2, 32'hFC000000);
    loadWord(6'd7, 32'h12345678);

    // Basic fetch with latency.
    fetchWord("fetch5", 6'd5, 32'hA5A5A5A5);

    // Stall four cycles in HOLD; load and fetch attempts must be ignored.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 6'd7, 1'b0);
      checkOutput($sformatf("stall%0d_instr", i), instruction, 32'hA5A5A5A5);
      checkOutput($sformatf("stall%0d_valid", i), {31'd0, ir_valid}, 32'd1);
      checkOutput($sformatf("stall%0d_pcinc", i), {31'd0, pc_inc}, 32'd0);
    end
    acceptWord("accept5");

    // Load during HOLD was dropped.
    fetchWord("refetch5", 6'd5, 32'hA5A5A5A5);
    acceptWord("accept5b");

    // Collision: write wins, fetch is ignored.
    applyStimulus(1'b1, 6'd3, 32'h11111111, 1'b1, 6'd3, 1'b0);
    checkOutput("coll_busy", {31'd0, fetch_busy}, 32'd0);
    idleCycle();
    checkOutput("coll_busy2", {31'd0, fetch_busy}, 32'd0);
    checkOutput("coll_valid", {31'd0, ir_valid}, 32'd0);
    fetchWord("fetch3", 6'd3, 32'h11111111);
    acceptWord("accept3");

    // Reset mid-HOLD; load and fetch during reset are ignored.
    fetchWord("fetch7", 6'd7, 32'h12345678);
    rst_n = 1'b0;
    applyStimulus(1'b1, 6'd7, 32'h0, 1'b1, 6'd7, 1'b0);
    checkAllZero("rstHold");
    rst_n = 1'b1;
    idleCycle();
    checkOutput("rstHold_idle", {31'd0, fetch_busy}, 32'd0);
    fetchWord("refetch7", 6'd7, 32'h12345678);
    acceptWord("accept7");

    // Halt word: no pc_inc, HALTED holds, fetches ignored, loads performed.
    fetchWord("fetch2", 6'd2, 32'hFC000000);
    applyStimulus(1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b1);
    checkOutput("halt_set", {31'd0, halt}, 32'd1);
    checkOutput("halt_pcinc", {31'd0, pc_inc}, 32'd0);
    checkOutput("halt_valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("halt_busy", {31'd0, fetch_busy}, 32'd1);
    loadWord(6'd9, 32'hCAFEF00D);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 6'd0, 32'h0, 1'b1, 6'd9, 1'b1);
      checkOutput($sformatf("halted%0d_halt", i), {31'd0, halt}, 32'd1);
      checkOutput($sformatf("halted%0d_valid", i), {31'd0, ir_valid}, 32'd0);
      checkOutput($sformatf("halted%0d_pcinc", i), {31'd0, pc_inc}, 32'd0);
    end

    // Only reset leaves HALTED; the word loaded while halted is readable.
    rst_n = 1'b0;
    idleCycle();
    checkAllZero("rstHalt");
    rst_n = 1'b1;
    fetchWord("fetch9", 6'd9, 32'hCAFEF00D);
    acceptWord("accept9");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
